alu_share_arb: RTL

Two-port arbiter that time-shares one combinational ALU between two independent requesters, for example the pipeline EX stage and a multi-cycle helper unit. Each requester uses a valid/ready request channel and a valid/ready response channel. The block latches the winning operands, drives the external ALU from registers, captures `out`/`zero`, and returns them to the owning requester. Only one operation is in flight at a time.

---
 rtl/alu_share_arb.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
// Time-shares one external combinational ALU between two valid/ready requesters.
// Accept edge N, EXEC in N+1, response from N+2; the response is held until its owner takes it, and no new request is accepted meanwhile.
module alu_share_arb #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic [31:0] req_in1_0,
    input  logic [31:0] req_in2_0,
    input  logic [5:0]  req_ctl_0,
    input  logic        req_sign_0,

    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic [31:0] req_in1_1,
    input  logic [31:0] req_in2_1,
    input  logic [5:0]  req_ctl_1,
    input  logic        req_sign_1,

    output logic        resp_valid_0,
    input  logic        resp_ready_0,
    output logic [31:0] resp_out_0,
    output logic        resp_zero_0,

    output logic        resp_valid_1,
    input  logic        resp_ready_1,
    output logic [31:0] resp_out_1,
    output logic        resp_zero_1,

    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [5:0]  alu_ctl,
    output logic        alu_sign,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,

    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic [31:0] in1_q, in1_d;
    logic [31:0] in2_q, in2_d;
    logic [5:0]  ctl_q, ctl_d;
    logic        sign_q, sign_d;
    logic [31:0] res_q, res_d;
    logic        zf_q, zf_d;

    logic        winner;
    logic        accept;
    logic        resp_hs;

    always_comb begin
        // On a tie the port that was not served last wins; fixed priority always picks port 0.
        if (req_valid_0 && req_valid_1) begin
            winner = RR_ENABLE ? ~last_q : 1'b0;
        end else begin
            winner = req_valid_1;
        end

        req_ready_0 = (state_q == IDLE) && req_valid_0 && !winner;
        req_ready_1 = (state_q == IDLE) && req_valid_1 && winner;
        accept      = req_ready_0 || req_ready_1;

        resp_valid_0 = (state_q == RESP) && !owner_q;
        resp_valid_1 = (state_q == RESP) && owner_q;
        resp_hs      = (resp_valid_0 && resp_ready_0) || (resp_valid_1 && resp_ready_1);

        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        ctl_d   = ctl_q;
        sign_d  = sign_q;
        res_d   = res_q;
        zf_d    = zf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = winner;
                    in1_d   = winner ? req_in1_1  : req_in1_0;
                    in2_d   = winner ? req_in2_1  : req_in2_0;
                    ctl_d   = winner ? req_ctl_1  : req_ctl_0;
                    sign_d  = winner ? req_sign_1 : req_sign_0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_out;
                zf_d    = alu_zero;
                state_d = RESP;
            end
            RESP: begin
                if (resp_hs) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            in1_q   <= 32'd0;
            in2_q   <= 32'd0;
            ctl_q   <= 6'd0;
            sign_q  <= 1'b0;
            res_q   <= 32'd0;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            ctl_q   <= ctl_d;
            sign_q  <= sign_d;
            res_q   <= res_d;
            zf_q    <= zf_d;
        end
    end

    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign alu_ctl     = ctl_q;
    assign alu_sign    = sign_q;
    assign resp_out_0  = res_q;
    assign resp_out_1  = res_q;
    assign resp_zero_0 = zf_q;
    assign resp_zero_1 = zf_q;
    assign busy        = (state_q != IDLE);

endmodule
